sequencer_track: RTL
====================

Name: sequencer_track

Overview:
- Multi-step, parametrised successor to the single-step sequencer player.
- Holds one note per step for NUM_STEPS steps and provides an edit cursor with up/down note editing.
- On each beat strobe, plays the note stored at the current beat and holds it for a programmable gate length.
- Sits between the measure counter / edge-detected buttons and the oscillator note input.

Parameters:
- NUM_STEPS, 8, number of steps in the track (2..16); STEP_W = $clog2(NUM_STEPS).
- NUM_NOTES, 14, note codes 0..NUM_NOTES-1; 0 = OFF (rest), 1 = lowC ... 13 = highC.
- GATE_CYCLES, 2000, clk cycles a note is held after its strobe (1..65535).

Ports:
- clk  input  1  system clock (10 kHz)
- rst  input  1  asynchronous, active-high reset
- sequencer_on  input  1  1 = sequencer mode, 0 = piano mode (track muted, edits ignored)
- beat  input  STEP_W  current step from the measure counter
- beat_strobe  input  1  single-cycle pulse when beat advances
- sel_next  input  1  edge-detected pulse: cursor +1
- sel_prev  input  1  edge-detected pulse: cursor -1
- note_up  input  1  edge-detected pulse: note at cursor +1
- note_down  input  1  edge-detected pulse: note at cursor -1
- clear  input  1  pulse: set all steps to OFF
- note_out  output  4  currently sounding note (0 when silent)
- gate  output  1  1 while note_out is nonzero
- retrig  output  1  one-cycle pulse at each note start
- cursor  output  STEP_W  edit cursor position
- cursor_note  output  4  note stored at cursor (for display)

Behaviour:
- Reset (async, rst=1):
  - all steps = 0, cursor = 0, note_out = 0, gate = 0, retrig = 0, gate counter = 0.
- Step memory:
  - NUM_STEPS x 4-bit registers; retained while sequencer_on = 0.
- Cursor:
  - sel_next: cursor+1, wrapping NUM_STEPS-1 -> 0.
  - sel_prev: cursor-1, wrapping 0 -> NUM_STEPS-1.
  - Both asserted in the same cycle: no change.
- Edit:
  - note_up: step[cursor]+1, wrapping NUM_NOTES-1 -> 0.
  - note_down: step[cursor]-1, wrapping 0 -> NUM_NOTES-1.
  - Both asserted in the same cycle: no change.
  - Edits apply to the cursor value *before* any same-cycle cursor move.
- Clear:
  - clear overrides same-cycle edits; the cursor is unaffected.
- Playback:
  - On beat_strobe with sequencer_on = 1, read step[beat] using the pre-edit value from that same cycle.
  - Next cycle (latency 1): note_out = step value; gate = (value != 0); counter loads GATE_CYCLES-1 if value != 0.
  - retrig = 1 for that one cycle if value != 0.
  - A rest (value 0) immediately silences any sounding note.
- Gate countdown:
  - While the counter is > 0 and no strobe occurs: counter decrements, note_out held.
  - When the counter reaches 0: note_out = 0 and gate = 0 on the following cycle.
- Simultaneous strobe and expiry:
  - The strobe wins; the new note loads and the counter reloads.
- Gate longer than the beat period:
  - A new strobe retriggers; there is no zero gap.
- Out-of-range beat (beat >= NUM_STEPS):
  - Treated as a rest.
- sequencer_on = 0:
  - note_out, gate and retrig are forced to 0 next cycle; counter cleared.
  - All edit, cursor and clear inputs are ignored.
  - cursor and cursor_note outputs remain valid.
- cursor_note:
  - Combinational read of step[cursor]; reflects an edit one cycle after the edit pulse.
- All outputs except cursor_note are registered.

Optional Feature:
- Macro: SEQ_TIE_EN.
- Defined:
  - If a strobe loads a nonzero note equal to the currently sounding note_out while gate = 1, the note is tied.
  - On a tie, retrig stays 0, the counter reloads, and gate stays continuously high.
- Undefined:
  - Every nonzero strobe pulses retrig, including repeated identical notes.

Test Plan:
- Reset: assert rst mid-playback with note_out = 5 -> all outputs 0 immediately; steps read back 0 via cursor_note.
- Edit wrap: cursor = 0; 14x note_up -> cursor_note 1..13 then 0; one note_down from 0 -> 13; note_up and note_down in the same cycle -> unchanged.
- Cursor wrap: NUM_STEPS = 8; sel_prev at cursor 0 -> 7; sel_next at 7 -> 0; both pulses in one cycle -> unchanged.
- Playback: step[3] = 8, GATE_CYCLES = 4; strobe with beat = 3 -> next cycle note_out = 8, gate = 1, retrig = 1; note_out = 8 for exactly 4 cycles, then 0.
- Rest and mode:
  - step[2] = 0 strobed while a note sounds -> note_out = 0 next cycle.
  - sequencer_on dropped -> outputs 0, note_up ignored, memory intact after re-enable.
- Tie: step[0] = step[1] = 6, gate longer than the beat period:
  - Macro defined: retrig pulses only at step 0 and gate never drops.
  - Macro undefined: retrig pulses at both steps.

Source files
------------

// File: rtl/sequencer_track.sv
// sequencer_track: multi-step note sequencer track.
//
// Holds one 4-bit note code per step (0 = rest, 1..NUM_NOTES-1 = pitches).
// An edit cursor selects the step shown on cursor_note and modified by
// note_up / note_down. On each beat_strobe the note stored at `beat` is
// played for GATE_CYCLES clock cycles.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   sequencer_on 1 = sequencer mode, 0 = piano mode (muted, edits ignored)
//   beat         current step from the measure counter
//   beat_strobe  single-cycle pulse when beat advances
//   sel_next     cursor +1 (wraps)
//   sel_prev     cursor -1 (wraps)
//   note_up      note at cursor +1 (wraps)
//   note_down    note at cursor -1 (wraps)
//   clear        set every step to rest
//   note_out     sounding note, 0 when silent (registered)
//   gate         high while note_out is nonzero (registered)
//   retrig       one-cycle pulse at each note start (registered)
//   cursor       edit cursor position (registered)
//   cursor_note  note stored at cursor (combinational)
//
// Build option: define SEQ_TIE_EN to tie a repeated note into the note
// already sounding (no retrig pulse, gate stays high, counter reloads).
// Without it every nonzero strobe pulses retrig.
//
// There are no handshakes in this block: every control input is a
// single-cycle pulse acted on in the cycle it is high.

module sequencer_track #(
  parameter int NUM_STEPS   = 8,
  parameter int NUM_NOTES   = 14,
  parameter int GATE_CYCLES = 2000,
  localparam int STEP_W     = $clog2(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sequencer_on,
  input  logic [STEP_W-1:0] beat,
  input  logic              beat_strobe,
  input  logic              sel_next,
  input  logic              sel_prev,
  input  logic              note_up,
  input  logic              note_down,
  input  logic              clear,
  output logic [3:0]        note_out,
  output logic              gate,
  output logic              retrig,
  output logic [STEP_W-1:0] cursor,
  output logic [3:0]        cursor_note
);

  localparam logic [3:0]        NOTE_MAX    = 4'(NUM_NOTES - 1);
  localparam logic [STEP_W-1:0] CUR_MAX     = STEP_W'(NUM_STEPS - 1);
  localparam logic [STEP_W:0]   STEPS_W     = (STEP_W + 1)'(NUM_STEPS);
  localparam logic [15:0]       GATE_LOAD   = 16'(GATE_CYCLES - 1);

  logic [3:0]  steps [NUM_STEPS];
  logic [15:0] gate_cnt;
  logic [3:0]  beat_note;
  logic        tie;

  assign cursor_note = steps[cursor];

  // Step memory is read before this cycle's edit lands, so playback sees
  // the pre-edit value. A beat past the last step plays as a rest.
  always_comb begin
    beat_note = 4'd0;
    if ({1'b0, beat} < STEPS_W) beat_note = steps[beat];
  end

`ifdef SEQ_TIE_EN
  assign tie = gate && (beat_note == note_out);
`else
  assign tie = 1'b0;
`endif

  // Step memory. Edits target the cursor value held in the register,
  // i.e. the position before any same-cycle cursor move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STEPS; i++) steps[i] <= 4'd0;
    end else if (sequencer_on) begin
      if (clear) begin
        for (int i = 0; i < NUM_STEPS; i++) steps[i] <= 4'd0;
      end else if (note_up && !note_down) begin
        steps[cursor] <= (steps[cursor] >= NOTE_MAX) ? 4'd0 : steps[cursor] + 4'd1;
      end else if (note_down && !note_up) begin
        steps[cursor] <= (steps[cursor] == 4'd0) ? NOTE_MAX : steps[cursor] - 4'd1;
      end
    end
  end

  // Edit cursor; opposing pulses in the same cycle cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor <= '0;
    end else if (sequencer_on) begin
      if (sel_next && !sel_prev) begin
        cursor <= (cursor >= CUR_MAX) ? '0 : cursor + 1'b1;
      end else if (sel_prev && !sel_next) begin
        cursor <= (cursor == '0) ? CUR_MAX : cursor - 1'b1;
      end
    end
  end

  // Playback. A strobe always takes priority over gate expiry so that a
  // gate longer than the beat period retriggers with no silent gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_out <= 4'd0;
      gate     <= 1'b0;
      retrig   <= 1'b0;
      gate_cnt <= 16'd0;
    end else begin
      retrig <= 1'b0;
      if (!sequencer_on) begin
        note_out <= 4'd0;
        gate     <= 1'b0;
        gate_cnt <= 16'd0;
      end else if (beat_strobe) begin
        if (beat_note != 4'd0) begin
          note_out <= beat_note;
          gate     <= 1'b1;
          gate_cnt <= GATE_LOAD;
          retrig   <= !tie;
        end else begin
          note_out <= 4'd0;
          gate     <= 1'b0;
          gate_cnt <= 16'd0;
        end
      end else if (gate_cnt != 16'd0) begin
        gate_cnt <= gate_cnt - 16'd1;
      end else begin
        note_out <= 4'd0;
        gate     <= 1'b0;
      end
    end
  end

endmodule
